// File: rtl/lab4_hilo_unit.sv
// lab4_hilo_unit: 32x32 radix-2 shift-add multiplier writing HI/LO, with mfhi/mflo read port.
// LAB4_HILO_SIGNED_MULT_EN enables signed mult (alu_op 0110); otherwise 0110 runs as multu.
module lab4_hilo_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  alu_op,
  input  logic        enhilo,
  input  logic        start,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_sel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);
  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;
  state_t state, state_nx;
  logic [31:0] a_q, b_q, a_in, b_in;
  logic [63:0] acc;
  logic [4:0]  cnt;
  logic        req;
  assign req   = start & enhilo & (alu_op == 4'b0110 | alu_op == 4'b0111);
  assign busy  = state != IDLE;
  assign rdata = hi_sel ? hi : lo;
`ifdef LAB4_HILO_SIGNED_MULT_EN
  logic sgn, neg;
  assign sgn  = alu_op == 4'b0110;
  assign a_in = (sgn & src_a[31]) ? -src_a : src_a;
  assign b_in = (sgn & src_b[31]) ? -src_b : src_b;
`else
  assign a_in = src_a;
  assign b_in = src_b;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req ? MUL : IDLE;
      MUL:     state_nx = (cnt == 5'd31) ? FIN : MUL;
      FIN:     state_nx = cnt[0] ? IDLE : FIN;
      default: state_nx = IDLE;
    endcase
  end
  // FIN spans two cycles: sign fix-up of the accumulator, then the HI/LO write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
`ifdef LAB4_HILO_SIGNED_MULT_EN
      neg   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        IDLE: if (req) begin
          a_q <= a_in;
          b_q <= b_in;
          acc <= '0;
          cnt <= '0;
`ifdef LAB4_HILO_SIGNED_MULT_EN
          neg <= sgn & (src_a[31] ^ src_b[31]);
`endif
        end
        MUL: begin
          acc <= acc + (b_q[cnt] ? ({32'b0, a_q} << cnt) : 64'd0);
          cnt <= cnt + 5'd1;
        end
        FIN: begin
          cnt <= cnt + 5'd1;
          if (cnt[0]) begin
            {hi, lo} <= acc;
            done     <= 1'b1;
          end
`ifdef LAB4_HILO_SIGNED_MULT_EN
          else acc <= neg ? -acc : acc;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lab4_hilo_unit.sv
// tb_lab4_hilo_unit: randomized scoreboard bench for lab4_hilo_unit against a plain-arithmetic product model.
module tb_lab4_hilo_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [3:0]  alu_op = '0;
  logic        enhilo = 1'b0, start = 1'b0, hi_sel = 1'b0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        busy, done;
  logic [31:0] hi, lo, rdata;

  lab4_hilo_unit dut (
    .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .enhilo(enhilo), .start(start),
    .src_a(src_a), .src_b(src_b), .hi_sel(hi_sel), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] p; int c; } exp_t;
  exp_t        q[$];
  int          cyc = 0, checks = 0, errors = 0, dones = 0;
  logic [31:0] cur_hi = '0, cur_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #2 hi_sel = 1'($urandom);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub;
`ifdef LAB4_HILO_SIGNED_MULT_EN
    longint sa, sb;
    if (op == 4'b0110) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
`endif
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every cycle HI/LO/rdata must match the last committed result; done pops the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done) begin
        dones++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got done=1 want done=0");
        end else begin
          e = q.pop_front();
          chk("latency", 64'(cyc - e.c), 64'd34);
          {cur_hi, cur_lo} = e.p;
        end
      end
      chk("hi", {32'b0, hi}, {32'b0, cur_hi});
      chk("lo", {32'b0, lo}, {32'b0, cur_lo});
      chk("rdata", {32'b0, rdata}, {32'b0, hi_sel ? cur_hi : cur_lo});
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    alu_op = op; enhilo = 1'b1; start = 1'b1; src_a = a; src_b = b;
    q.push_back('{model(op, a, b), cyc + 1});
    @(negedge clk);
    start = 1'b0; enhilo = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 60);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got done=0 want done=1 within 60 cycles");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;

    issue(4'b0111, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done();
    chk("multu_ff", {hi, lo}, 64'hFFFFFFFE_00000001);
    issue(4'b0110, 32'hFFFFFFFF, 32'h00000005);
    wait_done();
`ifdef LAB4_HILO_SIGNED_MULT_EN
    chk("mult_m1x5", {hi, lo}, 64'hFFFFFFFF_FFFFFFFB);
`else
    chk("mult_m1x5", {hi, lo}, 64'h00000004_FFFFFFFB);
`endif
    issue(4'b0110, 32'h80000000, 32'h80000000);
    wait_done();
    chk("mult_min", {hi, lo}, 64'h40000000_00000000);

    @(negedge clk);
    alu_op = 4'b0110; enhilo = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("ign_enhilo", {63'b0, busy}, 64'd0);
    alu_op = 4'b0101; enhilo = 1'b1;
    @(negedge clk);
    chk("ign_aluop", {63'b0, busy}, 64'd0);
    start = 1'b0; enhilo = 1'b0;

    issue(4'b0111, 32'd7, 32'd9);
    repeat (9) @(negedge clk);
    chk("bp_busy", {63'b0, busy}, 64'd1);
    alu_op = 4'b0111; enhilo = 1'b1; start = 1'b1; src_a = 32'd2; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0; enhilo = 1'b0;
    wait_done();
    chk("bp_first", {hi, lo}, 64'd63);
    issue(4'b0111, 32'd2, 32'd3);
    wait_done();
    chk("bp_after", {hi, lo}, 64'd6);

    issue(4'b0111, 32'd11, 32'd13);
    repeat (31) @(negedge clk);
    alu_op = 4'b0111; enhilo = 1'b1; start = 1'b1; src_a = 32'd5; src_b = 32'd5;
    wait_done();
    start = 1'b0; enhilo = 1'b0;
    @(negedge clk);
    chk("fin_ignored", {63'b0, busy}, 64'd0);
    chk("fin_result", {hi, lo}, 64'd143);

    for (int i = 0; i < 16; i++) begin
      issue($urandom_range(0, 1) ? 4'b0110 : 4'b0111, pick(), pick());
      wait_done();
    end

    issue(4'b0111, 32'h0001FFFF, 32'h0003FFFF);
    repeat (15) @(negedge clk);
    #2;
    q.delete();
    cur_hi = '0; cur_lo = '0;
    d0 = dones;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'b0, busy}, 64'd0);
    chk("mid_rst_hilo", {hi, lo}, 64'd0);
    chk("mid_rst_done", {63'b0, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_done_after_rst", 64'(dones), 64'(d0));
    issue(4'b0110, 32'h12345678, 32'hFEDCBA98);
    wait_done();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
